store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write buffer between the single-cycle core's load/store port and a multi-cycle data memory.
//  Accepts byte-masked stores (mask from the sub-word write logic), drains them in order over a req/ack port.
//  Services loads with stall signalling, so the core freezes only on a real memory dependency.
// PARAMETERS
//  DEPTH  4   store entries (power of two, >=2)
//  AW     32  address width (word address = addr[AW-1:2])
//  DW     32  data width (fixed 32; mask is DW/8 bits)
// PORTS
//  clk        in   1   sole clock, rising edge
//  reset      in   1   synchronous, active-low: reset==0 at posedge clears all state
//  st_valid   in   1   core presents a store
//  st_addr    in   AW  store byte address
//  st_data    in   DW  store data, already lane-replicated
//  st_mask    in   4   byte enables
//  st_ready   out  1   store accepted this cycle (= ~full)
//  ld_valid   in   1   core presents a load
//  ld_addr    in   AW  load byte address
//  ld_mask    in   4   bytes the load needs
//  ld_ready   out  1   ld_data valid this cycle; core stalls while ld_valid & ~ld_ready
//  ld_data    out  DW  raw word, before sub-word extract
//  mem_req    out  1   memory request, held until mem_ack
//  mem_we     out  1   1=write, 0=read
//  mem_addr   out  AW  word-aligned (addr[1:0]=0)
//  mem_wdata  out  DW  write data
//  mem_mask   out  4   write byte enables (4'b1111 on reads)
//  mem_ack    in   1   completes request at this posedge; allowed in the cycle req rises
//  mem_rdata  in   DW  read data, valid with mem_ack
//  empty      out  1   count==0
//  full       out  1   count==DEPTH
// BEHAVIOUR
//  Reset: count=0, rd/wr ptr=0, state=IDLE; mem_req=0, mem_we=0, ld_ready=0, st_ready=1, empty=1, full=0.
//  Reset during a pending mem_req drops it; buffered stores are discarded.
//  Enqueue: st_valid & ~full at posedge writes {addr,data,mask} at wr_ptr, ptr wraps mod DEPTH.
//  Full with st_valid=1: no accept, no pass-through. Enqueue+dequeue same edge: count unchanged.
//  FSM states IDLE, WR, RD; mem outputs decode from state and head entry only (no comb path from st_*).
//   IDLE -> RD  if ld_valid, no forward hit, no partial conflict (load has priority over drain)
//   IDLE -> WR  else if ~empty
//   WR: mem_we=1, head entry on mem_*; on mem_ack pop head -> IDLE
//   RD: mem_we=0, mem_addr={ld_addr[AW-1:2],2'b00}; on mem_ack ld_ready=1, ld_data=mem_rdata -> IDLE
//  Store -> earliest mem_req: the cycle after enqueue. Load miss: ld_ready no earlier than the cycle after ld_valid.
//  Conflict = any valid entry with matching word address and (entry mask & ld_mask)!=0.
//   A conflicting load waits until the conflicting entries drain (WR cycles), then issues RD.
//  ld_valid may drop mid-RD only on reset. The core holds the load stable until ld_ready.
//  Stores keep being accepted during WR/RD while not full.
// CONFIGURATION
//  STBUF_FWD_EN defined:
//   - If the youngest matching entry has mask covering ld_mask, ld_ready=1 in the same cycle.
//   - ld_data = that entry's data; no memory access.
//   - Any other conflict stalls as above.
//  Undefined: no forwarding; every conflict drains first, then RD.
// STRUCTURE
//  Package stbuf_pkg:
//   - stbuf_entry_t struct {addr, data, mask}
//   - stbuf_state_e enum {IDLE, WR, RD}
//   - localparams WORD_LSB=2, FULL_MASK=4'b1111
//  Sub-module stbuf_match: combinational per-entry word compare.
//   Outputs conflict, youngest-hit index and cover flag. Walks age order from rd_ptr.
// TESTING
//  1 Reset: hold reset=0 for 2 clks -> empty=1, mem_req=0, st_ready=1, ld_ready=0.
//  2 Drain order: 4 back-to-back sw (0x40..0x4C, data 1..4), mem_ack 2 clks after each req.
//     Expect full=1 after the 4th store and st_ready=0 on a 5th st_valid.
//     Expect writes in order 1,2,3,4, then empty=1.
//  3 Sb/lw conflict: sb 0xAB to 0x61 (mask 0010), then lw 0x60, mem word 0x11223344.
//     FWD off: WR then RD, ld_data=0x1122AB44. FWD on: still stall (partial cover), same data.
//  4 Forward hit (STBUF_FWD_EN): sw 0xDEADBEEF to 0x80, immediate lw 0x80.
//     Expect ld_ready same cycle, ld_data=0xDEADBEEF, no mem_req with mem_we=0.
//  5 Load priority: 2 stores to 0x100/0x104 queued, lw 0x200 in IDLE.
//     Expect RD issued before any WR; stores drain afterward in order.
//  6 Reset mid-WR: reset=0 while mem_req=1 and mem_ack=0, count=3.
//     Expect next cycle mem_req=0, empty=1; no later writes.

Source files
------------

// File: rtl/stbuf_pkg.sv
// stbuf_pkg: shared types and constants for the store buffer.
//   stbuf_entry_t  one buffered store {addr, data, mask}
//   stbuf_state_e  memory-port FSM states
//   WORD_LSB       number of byte-offset bits below the word address
//   FULL_MASK      byte enables used for word reads
package stbuf_pkg;

  localparam int unsigned WORD_LSB  = 2;
  localparam logic [3:0]  FULL_MASK = 4'b1111;

  // addr holds the full byte address; stores are sized for AW <= 32
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } stbuf_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } stbuf_state_e;

endpackage

// File: rtl/stbuf_match.sv
// stbuf_match: combinational load-vs-buffer word compare.
//   ent_word/ent_mask  word address and byte mask of every slot
//   rd_ptr, count      locate the valid slots in age order (oldest at rd_ptr)
//   ld_word, ld_mask   word address and bytes needed by the load
//   conflict           some valid entry overlaps the load's bytes
//   hit_idx            slot of the youngest overlapping entry
//   hit_cover          that youngest entry supplies every byte of ld_mask
module stbuf_match
  import stbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WW    = 30
) (
  input  logic [WW-1:0]              ent_word [DEPTH],
  input  logic [3:0]                 ent_mask [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [WW-1:0]              ld_word,
  input  logic [3:0]                 ld_mask,
  output logic                       conflict,
  output logic [$clog2(DEPTH)-1:0]   hit_idx,
  output logic                       hit_cover
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;
  logic [3:0]    ov;

  // Walk oldest to youngest so the last hit seen is the youngest one.
  always_comb begin
    conflict  = 1'b0;
    hit_idx   = '0;
    hit_cover = 1'b0;
    idx       = '0;
    ov        = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      ov  = ent_mask[idx] & ld_mask;
      if (((PW+1)'(k) < count) && (ent_word[idx] == ld_word) && (ov != '0)) begin
        conflict  = 1'b1;
        hit_idx   = idx;
        hit_cover = (ov == ld_mask);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the core load/store port and a
// multi-cycle data memory. Stores are queued and drained in order over a
// req/ack port; loads stall only while they depend on buffered stores.
//   clk, reset                 clock, synchronous active-low reset
//   st_valid/addr/data/mask    store in, st_ready = not full
//   ld_valid/addr/mask         load in, ld_ready/ld_data = load result
//   mem_req/we/addr/wdata/mask memory request, held until mem_ack
//   mem_ack/mem_rdata          memory completion and read data
//   empty, full                buffer occupancy flags
// Build option: define STBUF_FWD_EN to return a load straight from the
// youngest matching entry when that entry covers every requested byte.
module store_buffer
  import stbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [3:0]    st_mask,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [3:0]    ld_mask,
  output logic          ld_ready,
  output logic [DW-1:0] ld_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_mask,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned WW = AW - WORD_LSB;

  stbuf_entry_t  entries [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  stbuf_state_e  state, state_nx;

  logic          st_fire, pop, fwd;
  logic          conflict, hit_cover;
  logic [PW-1:0] hit_idx;
  logic [WW-1:0] ent_word [DEPTH];
  logic [3:0]    ent_mask [DEPTH];
  logic          unused_bits;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign st_ready = ~full;
  assign st_fire  = st_valid & ~full;
  assign pop      = (state == WR) & mem_ack;

  always_comb begin
    unused_bits = ^ld_addr[WORD_LSB-1:0];
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ent_word[k] = entries[k].addr[AW-1:WORD_LSB];
      ent_mask[k] = entries[k].mask;
      unused_bits = unused_bits ^ (^entries[k].addr[WORD_LSB-1:0]);
    end
`ifndef STBUF_FWD_EN
    unused_bits = unused_bits ^ hit_cover ^ (^hit_idx);
`endif
  end

  stbuf_match #(
    .DEPTH (DEPTH),
    .WW    (WW)
  ) u_match (
    .ent_word  (ent_word),
    .ent_mask  (ent_mask),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .ld_word   (ld_addr[AW-1:WORD_LSB]),
    .ld_mask   (ld_mask),
    .conflict  (conflict),
    .hit_idx   (hit_idx),
    .hit_cover (hit_cover)
  );

`ifdef STBUF_FWD_EN
  // No forwarding during RD: that read was issued with no conflict present.
  assign fwd = ld_valid & conflict & hit_cover & (state != RD);
`else
  assign fwd = 1'b0;
`endif

  // Storage needs no reset: slots are only read while counted valid.
  always_ff @(posedge clk) begin
    if (st_fire) begin
      entries[wr_ptr] <= '{addr: 32'(st_addr), data: st_data, mask: st_mask};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      if (st_fire) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({st_fire, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A store accepted this cycle is already at the head when the buffer is
  // empty, so the drain can start on the next cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (ld_valid && !conflict)  state_nx = RD;
        else if (!empty || st_fire) state_nx = WR;
      end
      WR:      if (mem_ack) state_nx = IDLE;
      RD:      if (mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state != IDLE);
    mem_we    = (state == WR);
    mem_wdata = entries[rd_ptr].data;
    mem_mask  = (state == WR) ? entries[rd_ptr].mask : FULL_MASK;
    mem_addr  = (state == RD) ? {ld_addr[AW-1:WORD_LSB], 2'b00}
                              : {entries[rd_ptr].addr[AW-1:WORD_LSB], 2'b00};
    ld_ready  = ((state == RD) & mem_ack) | fwd;
`ifdef STBUF_FWD_EN
    ld_data   = fwd ? entries[hit_idx].data : mem_rdata;
`else
    ld_data   = mem_rdata;
`endif
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_mask;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        empty;
  logic        full;

  store_buffer #(
    .DEPTH (4),
    .AW    (32),
    .DW    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_mask   (st_mask),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_mask   (ld_mask),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mask  (mem_mask),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .empty     (empty),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model and transaction log ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } txn_t;

  logic [31:0] mem [0:511];
  txn_t        log_q[$];
  int unsigned ack_delay = 1;
  bit          ack_en    = 1'b0;
  int unsigned wcnt      = 0;

  always @(negedge clk) begin
    if (!reset || !mem_req || !ack_en) begin
      wcnt    = 0;
      mem_ack = 1'b0;
    end else begin
      mem_ack   = (wcnt >= ack_delay);
      mem_rdata = mem[mem_addr[10:2]];
      wcnt++;
    end
  end

  always @(posedge clk) begin
    if (reset && mem_req && mem_ack) begin : logger
      txn_t t;
      t.we   = mem_we;
      t.addr = mem_addr;
      t.data = mem_we ? mem_wdata : mem_rdata;
      t.mask = mem_mask;
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_mask[b]) mem[mem_addr[10:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
      end
      log_q.push_back(t);
    end
  end

  // ---------------- checking helpers ----------------
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_mask  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_mask  = '0;
  endtask

  task automatic do_reset();
    ack_en = 1'b0;
    idle_in();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    log_q.delete();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    tick();
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mask  = m;
  endtask

  task automatic wait_ld_ready(input string name);
    int cyc = 0;
    while (ld_ready !== 1'b1 && cyc < 40) begin
      smp();
      cyc++;
    end
    chk(name, ld_ready, 1);
  endtask

  task automatic wait_drained(input string name);
    int cyc = 0;
    smp();
    while (!(empty === 1'b1 && mem_req === 1'b0) && cyc < 100) begin
      smp();
      cyc++;
    end
    chk(name, (empty === 1'b1 && mem_req === 1'b0), 1);
  endtask

  // ---------------- fill-phase vectors ----------------
  typedef struct {
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic        e_st_ready;
    logic        e_full;
    logic        e_empty;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_maddr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vt [6];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;

    vt[0] = '{1'b1, 32'h40, 32'h1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    vt[1] = '{1'b1, 32'h44, 32'h2, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h1};
    vt[2] = '{1'b1, 32'h48, 32'h3, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h1};
    vt[3] = '{1'b1, 32'h4C, 32'h4, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h1};
    vt[4] = '{1'b1, 32'h50, 32'h5, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h1};
    vt[5] = '{1'b0, 32'h0,  32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h1};

    // ---- 1: reset ----
    do_reset();
    smp();
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.st_ready", st_ready, 1);
    chk("rst.ld_ready", ld_ready, 0);

    // ---- 2: fill with memory stalled, then drain in order ----
    for (int i = 0; i < 6; i++) begin
      tick();
      st_valid = vt[i].st_valid;
      st_addr  = vt[i].st_addr;
      st_data  = vt[i].st_data;
      st_mask  = vt[i].st_mask;
      smp();
      chk($sformatf("fill%0d.st_ready", i), st_ready, vt[i].e_st_ready);
      chk($sformatf("fill%0d.full", i), full, vt[i].e_full);
      chk($sformatf("fill%0d.empty", i), empty, vt[i].e_empty);
      chk($sformatf("fill%0d.mem_req", i), mem_req, vt[i].e_req);
      if (vt[i].e_req) begin
        chk($sformatf("fill%0d.mem_we", i), mem_we, vt[i].e_we);
        chk($sformatf("fill%0d.mem_addr", i), mem_addr, vt[i].e_maddr);
        chk($sformatf("fill%0d.mem_wdata", i), mem_wdata, vt[i].e_wdata);
      end
    end
    tick();
    idle_in();
    ack_delay = 2;
    ack_en    = 1'b1;
    wait_drained("drain.done");
    chk("drain.count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk($sformatf("drain%0d.we", i), log_q[i].we, 1);
      chk($sformatf("drain%0d.addr", i), log_q[i].addr, 32'h40 + 32'(4 * i));
      chk($sformatf("drain%0d.data", i), log_q[i].data, 32'(i + 1));
    end
    chk("drain.st_ready", st_ready, 1);

    // ---- 3: sb then overlapping lw waits for the drain ----
    do_reset();
    mem[32'h60 >> 2] = 32'h11223344;
    ack_delay = 1;
    ack_en    = 1'b1;
    store(32'h61, 32'hABABABAB, 4'b0010);
    tick();
    idle_in();
    ld_valid = 1'b1;
    ld_addr  = 32'h60;
    ld_mask  = 4'hF;
    smp();
    chk("sblw.stall", ld_ready, 0);
    wait_ld_ready("sblw.ld_ready");
    chk("sblw.ld_data", ld_data, 32'h1122AB44);
    tick();
    idle_in();
    chk("sblw.count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("sblw.first_we", log_q[0].we, 1);
      chk("sblw.first_addr", log_q[0].addr, 32'h60);
      chk("sblw.first_mask", log_q[0].mask, 4'b0010);
      chk("sblw.second_we", log_q[1].we, 0);
      chk("sblw.second_addr", log_q[1].addr, 32'h60);
    end

    // ---- 4: sw then lw of the same word ----
    do_reset();
    ack_delay = 1;
    ack_en    = 1'b1;
    store(32'h80, 32'hDEADBEEF, 4'hF);
    tick();
    idle_in();
    ld_valid = 1'b1;
    ld_addr  = 32'h80;
    ld_mask  = 4'hF;
    smp();
`ifdef STBUF_FWD_EN
    chk("fwd.ld_ready_same_cycle", ld_ready, 1);
    chk("fwd.ld_data", ld_data, 32'hDEADBEEF);
    tick();
    idle_in();
    wait_drained("fwd.drained");
    chk("fwd.count", log_q.size(), 1);
    if (log_q.size() >= 1) chk("fwd.only_write", log_q[0].we, 1);
`else
    chk("nofwd.stall", ld_ready, 0);
    wait_ld_ready("nofwd.ld_ready");
    chk("nofwd.ld_data", ld_data, 32'hDEADBEEF);
    tick();
    idle_in();
    chk("nofwd.count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("nofwd.first_we", log_q[0].we, 1);
      chk("nofwd.second_we", log_q[1].we, 0);
    end
`endif

    // ---- 5: load priority over queued stores ----
    do_reset();
    mem[32'h200 >> 2] = 32'h55667788;
    ack_delay = 1;
    ack_en    = 1'b1;
    store(32'h100, 32'hA, 4'hF);
    ld_valid = 1'b1;
    ld_addr  = 32'h200;
    ld_mask  = 4'hF;
    store(32'h104, 32'hB, 4'hF);
    smp();
    chk("prio.rd_req", mem_req, 1);
    chk("prio.rd_we", mem_we, 0);
    chk("prio.rd_addr", mem_addr, 32'h200);
    tick();
    st_valid = 1'b0;
    smp();
    wait_ld_ready("prio.ld_ready");
    chk("prio.ld_data", ld_data, 32'h55667788);
    tick();
    idle_in();
    wait_drained("prio.drained");
    chk("prio.count", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      chk("prio.t0_we", log_q[0].we, 0);
      chk("prio.t0_addr", log_q[0].addr, 32'h200);
      chk("prio.t1_addr", log_q[1].addr, 32'h100);
      chk("prio.t1_data", log_q[1].data, 32'hA);
      chk("prio.t2_addr", log_q[2].addr, 32'h104);
      chk("prio.t2_data", log_q[2].data, 32'hB);
    end

    // ---- 6: reset while a write is pending ----
    do_reset();
    store(32'h20, 32'h1111, 4'hF);
    store(32'h24, 32'h2222, 4'hF);
    store(32'h28, 32'h3333, 4'hF);
    tick();
    idle_in();
    smp();
    chk("rstwr.pre_req", mem_req, 1);
    chk("rstwr.pre_empty", empty, 0);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    smp();
    chk("rstwr.post_req", mem_req, 0);
    chk("rstwr.post_empty", empty, 1);
    ack_en = 1'b1;
    repeat (10) smp();
    chk("rstwr.no_writes", log_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
